mac_seq_driver: RTL

//  Initiator side of the mac start/busy handshake. On a go pulse it walks LEN

---
 rtl/mac_seq_driver.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/mac_seq_driver.sv
// Sequencer that streams LEN operand pairs from two read ports into a MAC over
// its start/busy handshake and reports the accumulator change over the run.
module mac_seq_driver #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8,
    parameter int TIMEOUT    = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  go,
    input  logic [ADDR_WIDTH:0]   len,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [DATA_WIDTH-1:0] rd_a,
    input  logic [DATA_WIDTH-1:0] rd_b,
    output logic [DATA_WIDTH-1:0] mac_a,
    output logic [DATA_WIDTH-1:0] mac_b,
    output logic                  mac_start,
    input  logic                  mac_busy,
    input  logic [DATA_WIDTH-1:0] mac_dout,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] result,
    output logic                  timeout_err
);

    localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_LOAD, S_START, S_ACK, S_DRAIN, S_DONE
    } state_t;

    state_t                state, state_nxt;
    logic [ADDR_WIDTH:0]   len_q;
    logic [ADDR_WIDTH:0]   idx;
    logic [ADDR_WIDTH:0]   idx_inc;
    logic [DATA_WIDTH-1:0] base;
    logic [CNT_W-1:0]      ack_cnt;
    logic                  ack_expired;
    logic                  last_elem;

    // Wrapping difference keeps the run result independent of the MAC's
    // persistent accumulator contents.
    function automatic logic [DATA_WIDTH-1:0] acc_delta(
        input logic [DATA_WIDTH-1:0] now,
        input logic [DATA_WIDTH-1:0] start
    );
        return now - start;
    endfunction

    assign idx_inc     = idx + (ADDR_WIDTH+1)'(1);
    assign last_elem   = (idx_inc == len_q);
    assign ack_expired = (ack_cnt == CNT_W'(TIMEOUT - 1));
    assign rd_addr     = idx[ADDR_WIDTH-1:0];
    assign busy        = (state != S_IDLE);
    assign done        = (state == S_DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (go) begin
                    state_nxt = (len == '0) ? S_DONE : S_FETCH;
                end
            end
            S_FETCH: state_nxt = S_LOAD;
            S_LOAD:  state_nxt = S_START;
            S_START: state_nxt = S_ACK;
            S_ACK: begin
                if (mac_busy) begin
                    state_nxt = S_DRAIN;
                end else if (ack_expired) begin
                    state_nxt = S_DONE;
                end
            end
            S_DRAIN: begin
                if (!mac_busy) begin
                    state_nxt = last_elem ? S_DONE : S_FETCH;
                end
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Operand stage: mac_a/mac_b captured from the read ports as mac_start is raised
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            len_q       <= '0;
            idx         <= '0;
            base        <= '0;
            ack_cnt     <= '0;
            mac_a       <= '0;
            mac_b       <= '0;
            mac_start   <= 1'b0;
            result      <= '0;
            timeout_err <= 1'b0;
        end else begin
            mac_start <= (state == S_LOAD);
            case (state)
                S_IDLE: begin
                    if (go) begin
                        timeout_err <= 1'b0;
                        idx         <= '0;
                        if (len != '0) begin
                            len_q <= len;
                            base  <= mac_dout;
                        end else begin
                            result <= '0;
                        end
                    end
                end
                S_LOAD: begin
                    mac_a <= rd_a;
                    mac_b <= rd_b;
                end
                S_START: ack_cnt <= '0;
                S_ACK: begin
                    if (!mac_busy) begin
                        if (ack_expired) begin
                            timeout_err <= 1'b1;
                            result      <= '0;
                        end else begin
                            ack_cnt <= ack_cnt + CNT_W'(1);
                        end
                    end
                end
                S_DRAIN: begin
                    if (!mac_busy) begin
                        idx <= idx_inc;
                        if (last_elem) begin
                            result <= acc_delta(mac_dout, base);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
